arm_alu: RTL and testbench
==========================

// Module: arm_alu
// PURPOSE
//   32-bit integer ALU for the armcpu execute stage. Computes one of eight
//   operations on operands a and b, selected by a 3-bit function code.
//   Result and carry-out are registered: one cycle of latency, then held.
//   Feeds the writeback mux and the flag logic.
// PARAMETERS
//   WIDTH   32   operand/result width in bits (only 32 is verified)
// PORTS
//   clk    input   1      system clock, rising-edge active
//   rst_n  input   1      asynchronous, active-low reset
//   a      input   WIDTH  operand A
//   b      input   WIDTH  operand B
//   func   input   3      operation select (encodings below)
//   out    output  WIDTH  registered result
//   cout   output  1      registered carry/borrow/shift-out bit
// BEHAVIOUR
//   Clocking and reset:
//   - One clock domain, clk. Reset is asynchronous and active-low.
//   - rst_n low: out=0 and cout=0 immediately, without waiting for clk.
//   - rst_n rising: no output change until the next rising edge of clk.
//   Latency:
//   - Every rising clk edge with rst_n high captures f(a,b,func) into out and cout.
//   - Latency is exactly 1 cycle. No handshake: every cycle is accepted.
//   - Inputs must be stable around the clk edge.
//   Function codes (the `define names live in alu.v and are shared with the bench):
//   - 000 ALU_ADD_FUNCTION  out=a+b mod 2^32;  cout = bit 32 of the 33-bit sum
//   - 001 ALU_SUB_FUNCTION  out=a-b mod 2^32;  cout = 1 when no borrow (a>=b unsigned; ARM C)
//   - 010 ALU_AND_FUNCTION  out=a&b;  cout=0
//   - 011 ALU_OR_FUNCTION   out=a|b;  cout=0
//   - 100 ALU_XOR_FUNCTION  out=a^b;  cout=0
//   - 101 ALU_LSL_FUNCTION  out=a<<b[4:0]
//       cout = last bit shifted out; shift amount 0 -> cout=0
//   - 110 ALU_LSR_FUNCTION  out=a>>b[4:0] (zero fill)
//       cout = last bit shifted out; shift amount 0 -> cout=0
//   - 111 ALU_ASR_FUNCTION  out=$signed(a)>>>b[4:0] (sign fill); cout as for LSR
//   Width rules:
//   - All arithmetic is modulo 2^32. Overflow wraps silently; only cout reports it.
//   - Shifts use only b[4:0]. b[31:5] are ignored.
//   Boundaries:
//   - ADD ffffffff+00000001 -> out=0, cout=1.
//   - SUB x-x -> out=0, cout=1.
//   - SUB 0-1 -> out=ffffffff, cout=0.
//   - If func changes every cycle, each registered result reflects the func
//     sampled at that edge only.
//   - If reset is asserted mid-stream, the pending result is discarded.
// TESTING
//   1. Random ADD, 600 vectors: a,b = $urandom; check out==a+b mod 2^32 one cycle later.
//   2. ADD a=ffffffff b=00000001 -> out=00000000, cout=1.
//      ADD a=1 b=2 -> out=3, cout=0.
//   3. SUB a=5 b=7 -> out=fffffffe, cout=0.
//      SUB a=7 b=5 -> out=2, cout=1.
//   4. Logic ops, a=f0f0f0f0 b=ff00ff00:
//      AND -> f000f000; OR -> fff0fff0; XOR -> 0ff00ff0; cout=0 each.
//   5. LSL a=80000001 b=1 -> out=00000002, cout=1.
//      ASR a=80000000 b=4 -> out=f8000000, cout=0.
//   6. rst_n low mid-stream with out!=0 -> out=0 and cout=0 at once, with clk held.
//      After release, the first edge loads a fresh result.

Source files
------------

// File: rtl/arm_alu.sv
// Registered 32-bit execute-stage ALU: eight operations selected by func,
// result and carry/borrow/shift-out bit captured one cycle after the inputs.
module arm_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       func,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_SUB = 3'b001,
        FN_AND = 3'b010,
        FN_OR  = 3'b011,
        FN_XOR = 3'b100,
        FN_LSL = 3'b101,
        FN_LSR = 3'b110,
        FN_ASR = 3'b111
    } alu_func_e;

    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_lsl;
    logic [WIDTH:0]   w_lsr;
    logic [WIDTH:0]   w_asr;
    logic [WIDTH-1:0] w_out;
    logic             w_cout;
    logic [WIDTH-1:0] r_out;
    logic             r_cout;

    assign w_shamt = b[SHW-1:0];
    assign w_sum   = {1'b0, a} + {1'b0, b};
    // a + ~b + 1: the carry out of bit WIDTH is the ARM "no borrow" flag.
    assign w_diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // One guard bit beyond the operand catches the last bit shifted out;
    // a zero shift leaves the guard at 0, which is the required cout.
    assign w_lsl = {1'b0, a} << w_shamt;
    assign w_lsr = {a, 1'b0} >> w_shamt;
    assign w_asr = $unsigned($signed({a, 1'b0}) >>> w_shamt);

    always_comb begin
        w_out  = '0;
        w_cout = 1'b0;
        unique case (alu_func_e'(func))
            FN_ADD: begin
                w_out  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
            end
            FN_SUB: begin
                w_out  = w_diff[WIDTH-1:0];
                w_cout = w_diff[WIDTH];
            end
            FN_AND: w_out = a & b;
            FN_OR:  w_out = a | b;
            FN_XOR: w_out = a ^ b;
            FN_LSL: begin
                w_out  = w_lsl[WIDTH-1:0];
                w_cout = w_lsl[WIDTH];
            end
            FN_LSR: begin
                w_out  = w_lsr[WIDTH:1];
                w_cout = w_lsr[0];
            end
            FN_ASR: begin
                w_out  = w_asr[WIDTH:1];
                w_cout = w_asr[0];
            end
            default: begin
                w_out  = '0;
                w_cout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_out  <= w_out;
            r_cout <= w_cout;
        end
    end

    assign out  = r_out;
    assign cout = r_cout;

endmodule

// File: tb/tb_arm_alu.sv
// Directed-vector and random-ADD bench for arm_alu, plus asynchronous reset
// sequences checked between clock edges.
module tb_arm_alu;

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_AND = 3'b010;
    localparam logic [2:0] F_OR  = 3'b011;
    localparam logic [2:0] F_XOR = 3'b100;
    localparam logic [2:0] F_LSL = 3'b101;
    localparam logic [2:0] F_LSR = 3'b110;
    localparam logic [2:0] F_ASR = 3'b111;

    typedef struct {
        string       name;
        logic [2:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_cout;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  func;
    logic [31:0] out;
    logic        cout;

    int checks;
    int failures;

    arm_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .func  (func),
        .out   (out),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string name, input logic [31:0] exp);
        checks++;
        if (out !== exp) begin
            failures++;
            $display("FAIL %s out: got %08h expected %08h", name, out, exp);
        end
    endtask

    task automatic check_cout(input string name, input logic exp);
        checks++;
        if (cout !== exp) begin
            failures++;
            $display("FAIL %s cout: got %0b expected %0b", name, cout, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        func = f;
        a    = va;
        b    = vb;
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [32:0] rsum;
        int          rand_fail;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        func     = F_ADD;
        a        = '0;
        b        = '0;

        vecs.push_back('{"add_wrap",   F_ADD, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1});
        vecs.push_back('{"and_after_c",F_AND, 32'hffffffff, 32'h0000ffff, 32'h0000ffff, 1'b0});
        vecs.push_back('{"add_small",  F_ADD, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0});
        vecs.push_back('{"sub_5_7",    F_SUB, 32'h00000005, 32'h00000007, 32'hfffffffe, 1'b0});
        vecs.push_back('{"sub_7_5",    F_SUB, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1});
        vecs.push_back('{"sub_x_x",    F_SUB, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1});
        vecs.push_back('{"sub_0_1",    F_SUB, 32'h00000000, 32'h00000001, 32'hffffffff, 1'b0});
        vecs.push_back('{"and",        F_AND, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 1'b0});
        vecs.push_back('{"or",         F_OR,  32'hf0f0f0f0, 32'hff00ff00, 32'hfff0fff0, 1'b0});
        vecs.push_back('{"xor",        F_XOR, 32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 1'b0});
        vecs.push_back('{"lsl_1",      F_LSL, 32'h80000001, 32'h00000001, 32'h00000002, 1'b1});
        vecs.push_back('{"asr_4",      F_ASR, 32'h80000000, 32'h00000004, 32'hf8000000, 1'b0});
        vecs.push_back('{"lsr_1",      F_LSR, 32'h80000001, 32'h00000001, 32'h40000000, 1'b1});
        vecs.push_back('{"lsr_0",      F_LSR, 32'h0000000f, 32'h00000000, 32'h0000000f, 1'b0});
        vecs.push_back('{"lsl_hib",    F_LSL, 32'h00000001, 32'hffffffe4, 32'h00000010, 1'b0});
        vecs.push_back('{"asr_31",     F_ASR, 32'hc0000000, 32'h0000001f, 32'hffffffff, 1'b1});
        vecs.push_back('{"lsl_31",     F_LSL, 32'hffffffff, 32'h0000001f, 32'h80000000, 1'b1});
        vecs.push_back('{"lsr_31",     F_LSR, 32'h80000000, 32'h0000001f, 32'h00000001, 1'b0});
        vecs.push_back('{"asr_pos",    F_ASR, 32'h40000008, 32'h00000004, 32'h04000000, 1'b1});
        vecs.push_back('{"lsl_0",      F_LSL, 32'hdeadbeef, 32'h00000020, 32'hdeadbeef, 1'b0});

        #12;
        check_out("reset_out", 32'h0);
        check_cout("reset_cout", 1'b0);

        // Hold values stable across a rising edge while still in reset.
        @(posedge clk);
        #1;
        check_out("reset_hold_out", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back vectors: func changes every cycle.
        foreach (vecs[i]) begin
            drive(vecs[i].func, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1;
            check_out(vecs[i].name, vecs[i].exp_out);
            check_cout(vecs[i].name, vecs[i].exp_cout);
        end

        rand_fail = 0;
        for (int i = 0; i < 600; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rsum = {1'b0, ra} + {1'b0, rb};
            drive(F_ADD, ra, rb);
            @(posedge clk);
            #1;
            checks++;
            if (out !== rsum[31:0] || cout !== rsum[32]) begin
                failures++;
                if (rand_fail < 5)
                    $display("FAIL rand_add %08h+%08h: got %08h/%0b expected %08h/%0b",
                             ra, rb, out, cout, rsum[31:0], rsum[32]);
                rand_fail++;
            end
        end

        // Asynchronous reset while the output holds a carry result.
        drive(F_ADD, 32'hffffffff, 32'h00000003);
        @(posedge clk);
        #1;
        check_out("pre_rst_out", 32'h00000002);
        check_cout("pre_rst_cout", 1'b1);
        drive(F_ADD, 32'h00000010, 32'h00000020);
        #1;
        rst_n = 1'b0;
        #1;
        check_out("async_rst_out", 32'h0);
        check_cout("async_rst_cout", 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_discard_out", 32'h0);

        // Release between edges: nothing changes until the next rising edge.
        @(negedge clk);
        func  = F_SUB;
        a     = 32'h00000009;
        b     = 32'h00000004;
        rst_n = 1'b1;
        #2;
        check_out("release_hold_out", 32'h0);
        check_cout("release_hold_cout", 1'b0);
        @(posedge clk);
        #1;
        check_out("post_rst_out", 32'h00000005);
        check_cout("post_rst_cout", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
